// File: rtl/program_loader_if.sv
// Byte-stream input and program-RAM write bus of the program loader.
// The master drives received bytes; the slave (the loader) drives RAM writes and status.
interface program_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_hold;
  logic       done;
  logic       err;

  modport master (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_data, cpu_hold, done, err
  );

  modport slave (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_data, cpu_hold, done, err
  );
endinterface

// File: rtl/program_loader.sv
// Receives a framed program image (SYNC, LEN, data, CHK) and writes it into program RAM,
// holding the CPU in reset for the duration of each frame.
module program_loader #(
  parameter int         SIZE    = 256,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 100000
) (
  input logic             clk,
  input logic             rst,
  program_loader_if.slave bus
);
  localparam int            IW        = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [9:0]    SIZE_W    = 10'(SIZE);

  typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_DATA, ST_SUM} state_e;

  state_e        state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    acc_q, acc_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          mem_we_q, mem_we_d;
  logic [7:0]    mem_addr_q, mem_addr_d;
  logic [7:0]    mem_data_q, mem_data_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          rx_sync;
  logic [8:0]    len_n;
  logic          len_bad;
  logic [7:0]    acc_sum;
  logic          timeout;

  assign rx_sync = bus.rx_valid && (bus.rx_data == SYNC);
  assign len_n   = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
  assign len_bad = {1'b0, len_n} > SIZE_W;
  assign acc_sum = acc_q + bus.rx_data;
  // A strobe in the same cycle always wins over an expiring idle counter.
  assign timeout = (state_q != ST_IDLE) && !bus.rx_valid && (idle_q == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (rx_sync) state_d = ST_LEN;
      ST_LEN: begin
        if (timeout)           state_d = ST_IDLE;
        else if (bus.rx_valid) state_d = len_bad ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (timeout)                            state_d = ST_IDLE;
        else if (bus.rx_valid && cnt_q == 9'd1) state_d = ST_SUM;
      end
      ST_SUM: if (timeout || bus.rx_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    acc_d      = acc_q;
    idle_d     = (state_q == ST_IDLE || bus.rx_valid) ? '0 : idle_q + 1'b1;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    err_d      = err_q;
    if (timeout) begin
      err_d      = 1'b1;
      cpu_hold_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_sync) begin
            cpu_hold_d = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
            addr_d     = 8'd0;
            acc_d      = 8'd0;
          end
        end
        ST_LEN: begin
          if (bus.rx_valid) begin
            cnt_d = len_n;
            acc_d = acc_sum;
            if (len_bad) begin
              err_d      = 1'b1;
              cpu_hold_d = 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (bus.rx_valid) begin
            mem_we_d   = 1'b1;
            mem_addr_d = addr_q;
            mem_data_d = bus.rx_data;
            addr_d     = addr_q + 8'd1;
            acc_d      = acc_sum;
            cnt_d      = cnt_q - 9'd1;
          end
        end
        ST_SUM: begin
          if (bus.rx_valid) begin
            done_d     = (acc_sum == 8'd0);
            err_d      = (acc_sum != 8'd0);
            cpu_hold_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      acc_q      <= '0;
      idle_q     <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      acc_q      <= acc_d;
      idle_q     <= idle_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: two instances (SIZE 256 and SIZE 16, both TIMEOUT 20)
// with expected RAM writes and end-of-frame status queued ahead and popped by monitors.
module tb_program_loader;
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  program_loader_if if_a ();
  program_loader_if if_b ();

  program_loader #(.SIZE(256), .SYNC(8'hA5), .TIMEOUT(20)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  program_loader #(.SIZE(16),  .SYNC(8'hA5), .TIMEOUT(20)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  int         vec_cnt  = 0;
  int         miss_cnt = 0;
  wr_t        wr_q_a[$];
  wr_t        wr_q_b[$];
  logic [1:0] st_q_a[$];
  logic [1:0] st_q_b[$];
  logic [7:0] stim_q[$];
  wr_t        exp_wr_a, exp_wr_b;
  logic [1:0] exp_st_a, exp_st_b;
  logic       hold_prev_a = 1'b0;
  logic       hold_prev_b = 1'b0;
  logic [7:0] acc;
  logic [7:0] val;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic report_extra(input string name, input logic [15:0] act);
    vec_cnt++;
    miss_cnt++;
    $display("[TB] FAIL %s: got %h, expected nothing", name, act);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends every byte in stim_q on consecutive edges to instance 0 (a) or 1 (b).
  task automatic apply_stimulus(input int which);
    for (int i = 0; i < stim_q.size(); i++) begin
      if (which == 0) begin
        if_a.rx_data  = stim_q[i];
        if_a.rx_valid = 1'b1;
      end else begin
        if_b.rx_data  = stim_q[i];
        if_b.rx_valid = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if_a.rx_valid = 1'b0;
    if_b.rx_valid = 1'b0;
    stim_q.delete();
  endtask

  task automatic push_wr_a(input logic [7:0] addr, input logic [7:0] data);
    wr_q_a.push_back('{addr: addr, data: data});
  endtask

  always @(negedge clk) begin
    if (if_a.mem_we) begin
      if (wr_q_a.size() == 0) report_extra("a write", {if_a.mem_addr, if_a.mem_data});
      else begin
        exp_wr_a = wr_q_a.pop_front();
        check_output("a write", {if_a.mem_addr, if_a.mem_data}, exp_wr_a);
      end
    end
    if (hold_prev_a && !if_a.cpu_hold) begin
      if (st_q_a.size() == 0) report_extra("a status", {14'd0, if_a.done, if_a.err});
      else begin
        exp_st_a = st_q_a.pop_front();
        check_output("a status", {14'd0, if_a.done, if_a.err}, {14'd0, exp_st_a});
      end
    end
    hold_prev_a = if_a.cpu_hold;
  end

  always @(negedge clk) begin
    if (if_b.mem_we) begin
      if (wr_q_b.size() == 0) report_extra("b write", {if_b.mem_addr, if_b.mem_data});
      else begin
        exp_wr_b = wr_q_b.pop_front();
        check_output("b write", {if_b.mem_addr, if_b.mem_data}, exp_wr_b);
      end
    end
    if (hold_prev_b && !if_b.cpu_hold) begin
      if (st_q_b.size() == 0) report_extra("b status", {14'd0, if_b.done, if_b.err});
      else begin
        exp_st_b = st_q_b.pop_front();
        check_output("b status", {14'd0, if_b.done, if_b.err}, {14'd0, exp_st_b});
      end
    end
    hold_prev_b = if_b.cpu_hold;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    if_a.rx_data  = 8'h00;
    if_a.rx_valid = 1'b0;
    if_b.rx_data  = 8'h00;
    if_b.rx_valid = 1'b0;
    rst = 1'b0;
    idle_cycles(3);
    check_output("reset a outputs", {10'd0, if_a.mem_we, if_a.cpu_hold, if_a.done, if_a.err, 2'd0}, 16'd0);
    check_output("reset a bus", {if_a.mem_addr, if_a.mem_data}, 16'd0);
    check_output("reset b outputs", {12'd0, if_b.mem_we, if_b.cpu_hold, if_b.done, if_b.err}, 16'd0);
    rst = 1'b1;
    idle_cycles(2);

    $display("[TB] good frame");
    push_wr_a(8'h00, 8'h10);
    push_wr_a(8'h01, 8'h20);
    push_wr_a(8'h02, 8'h30);
    st_q_a.push_back(2'b10);
    stim_q = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9D};
    apply_stimulus(0);
    check_output("good frame flags", {13'd0, if_a.cpu_hold, if_a.done, if_a.err}, 16'h0002);
    idle_cycles(3);

    $display("[TB] bad checksum, then good frame clears err");
    push_wr_a(8'h00, 8'h42);
    st_q_a.push_back(2'b01);
    stim_q = '{8'hA5, 8'h01, 8'h42, 8'h00};
    apply_stimulus(0);
    check_output("bad checksum flags", {13'd0, if_a.cpu_hold, if_a.done, if_a.err}, 16'h0001);
    idle_cycles(2);
    stim_q = '{8'hA5};
    apply_stimulus(0);
    check_output("sync clears err", {13'd0, if_a.cpu_hold, if_a.done, if_a.err}, 16'h0004);
    push_wr_a(8'h00, 8'h55);
    st_q_a.push_back(2'b10);
    stim_q = '{8'h01, 8'h55, 8'hAA};
    apply_stimulus(0);
    idle_cycles(3);

    // 0x02 + 0xA5 + 0xA5 + 0xB4 = 0x200, so this frame is good.
    $display("[TB] noise and in-frame sync");
    push_wr_a(8'h00, 8'hA5);
    push_wr_a(8'h01, 8'hA5);
    st_q_a.push_back(2'b10);
    stim_q = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'hA5, 8'hA5, 8'hB4};
    apply_stimulus(0);
    check_output("noise frame flags", {13'd0, if_a.cpu_hold, if_a.done, if_a.err}, 16'h0002);
    idle_cycles(3);

    $display("[TB] 256-byte frame");
    acc = 8'h00;
    stim_q.push_back(8'hA5);
    stim_q.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      val = 8'(i) ^ 8'h3C;
      acc = acc + val;
      stim_q.push_back(val);
      push_wr_a(8'(i), val);
    end
    stim_q.push_back(8'h00 - acc);
    st_q_a.push_back(2'b10);
    apply_stimulus(0);
    idle_cycles(2);
    check_output("256 frame flags", {13'd0, if_a.cpu_hold, if_a.done, if_a.err}, 16'h0002);
    check_output("bus holds last write", {if_a.mem_addr, if_a.mem_data}, {8'hFF, 8'hFF ^ 8'h3C});

    $display("[TB] length check on SIZE 16");
    st_q_b.push_back(2'b01);
    stim_q = '{8'hA5, 8'h11};
    apply_stimulus(1);
    check_output("too long flags", {13'd0, if_b.cpu_hold, if_b.done, if_b.err}, 16'h0001);
    idle_cycles(2);
    // 0x10 + (0 + 1 + ... + 15) = 0x88, so CHK = 0x78.
    stim_q.push_back(8'hA5);
    stim_q.push_back(8'h10);
    for (int i = 0; i < 16; i++) begin
      stim_q.push_back(8'(i));
      wr_q_b.push_back('{addr: 8'(i), data: 8'(i)});
    end
    stim_q.push_back(8'h78);
    st_q_b.push_back(2'b10);
    apply_stimulus(1);
    check_output("full size flags", {13'd0, if_b.cpu_hold, if_b.done, if_b.err}, 16'h0002);
    idle_cycles(2);

    $display("[TB] timeout");
    push_wr_a(8'h00, 8'h01);
    st_q_a.push_back(2'b01);
    stim_q = '{8'hA5, 8'h04, 8'h01};
    apply_stimulus(0);
    idle_cycles(19);
    check_output("before timeout", {13'd0, if_a.cpu_hold, if_a.done, if_a.err}, 16'h0004);
    idle_cycles(1);
    check_output("at timeout", {13'd0, if_a.cpu_hold, if_a.done, if_a.err}, 16'h0001);
    idle_cycles(3);

    $display("[TB] reset mid-frame");
    push_wr_a(8'h00, 8'h11);
    push_wr_a(8'h01, 8'h22);
    st_q_a.push_back(2'b00);
    stim_q = '{8'hA5, 8'h04, 8'h11, 8'h22};
    apply_stimulus(0);
    rst = 1'b0;
    idle_cycles(1);
    check_output("reset mid outputs", {10'd0, if_a.mem_we, if_a.cpu_hold, if_a.done, if_a.err, 2'd0}, 16'd0);
    check_output("reset mid bus", {if_a.mem_addr, if_a.mem_data}, 16'd0);
    rst = 1'b1;
    idle_cycles(2);
    push_wr_a(8'h00, 8'h77);
    st_q_a.push_back(2'b10);
    stim_q = '{8'hA5, 8'h01, 8'h77, 8'h88};
    apply_stimulus(0);
    idle_cycles(4);

    check_output("a writes drained", 16'(wr_q_a.size()), 16'd0);
    check_output("b writes drained", 16'(wr_q_b.size()), 16'd0);
    check_output("a status drained", 16'(st_q_a.size()), 16'd0);
    check_output("b status drained", 16'(st_q_b.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
